platform_nios2_gen2_0_cpu_debug_host_shifter: RTL and testbench



---
 rtl/platform_nios2_gen2_0_cpu_debug_host_shifter.sv | 213 +++++++++++++++++++++
 tb/tb_platform_nios2_gen2_0_cpu_debug_host_shifter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_nios2_gen2_0_cpu_debug_host_shifter.sv
// platform_nios2_gen2_0_cpu_debug_host_shifter: drives a Nios II debug slave's virtual JTAG port
// (UIR->CDR->SDRxN->UDR->RTI) from system-clock commands. Option macro: DBG_HOST_IR_CACHE_EN. Rev 1.0
`default_nettype none

module platform_nios2_gen2_0_cpu_debug_host_shifter #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int DIV_W = $clog2(TCK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
  localparam logic [5:0]       BIT_LAST = 6'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UIR   = 3'd1,
    S_CDR   = 3'd2,
    S_SHIFT = 3'd3,
    S_UDR   = 3'd4,
    S_RTI   = 3'd5,
    S_RSP   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic [DR_WIDTH-1:0] sr_q, sr_d;
  logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic                tck_q, tck_d;
  logic                tdi_q, tdi_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                uir_q, uir_d, cdr_q, cdr_d, sdr_q, sdr_d, udr_q, udr_d, rti_q, rti_d;
`ifdef DBG_HOST_IR_CACHE_EN
  logic [IR_WIDTH-1:0] ir_cache_q, ir_cache_d;
  logic                ir_cache_vld_q, ir_cache_vld_d;
`endif

  logic accept, last_cyc, period_end;

  always_comb begin
    accept     = cmd_valid & cmd_ready_q;
    last_cyc   = (div_cnt_q == DIV_LAST);
    period_end = last_cyc & tck_q;

    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    rsp_data_d = rsp_data_q;
    rsp_ir_d   = rsp_ir_q;
    ir_in_d    = ir_in_q;
    tck_d      = tck_q;
    tdi_d      = tdi_q;
`ifdef DBG_HOST_IR_CACHE_EN
    ir_cache_d     = ir_cache_q;
    ir_cache_vld_d = ir_cache_vld_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ir_in_d   = cmd_ir;
          sr_d      = cmd_data;
          div_cnt_d = '0;
          tck_d     = 1'b0;
`ifdef DBG_HOST_IR_CACHE_EN
          // A repeat of the cached IR skips the UIR period entirely
          state_d        = (ir_cache_vld_q && (cmd_ir == ir_cache_q)) ? S_CDR : S_UIR;
          ir_cache_d     = cmd_ir;
          ir_cache_vld_d = 1'b1;
`else
          state_d = S_UIR;
`endif
        end
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: begin
        if (last_cyc) begin
          div_cnt_d = '0;
          tck_d     = ~tck_q;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
        // Capture TDO on the clk edge that raises TCK
        if (state_q == S_SHIFT && last_cyc && !tck_q)
          sr_d = {vji_tdo, sr_q[DR_WIDTH-1:1]};
        if (period_end) begin
          case (state_q)
            S_UIR: begin
              rsp_ir_d = vji_ir_out;
              state_d  = S_CDR;
            end
            S_CDR: begin
              bit_cnt_d = '0;
              state_d   = S_SHIFT;
            end
            S_SHIFT: begin
              if (bit_cnt_q == BIT_LAST) state_d = S_UDR;
              else bit_cnt_d = bit_cnt_q + 6'd1;
            end
            S_UDR: state_d = S_RTI;
            S_RTI: begin
              rsp_data_d = sr_q;
              state_d    = S_RSP;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase

    // TDI only moves on TCK falling edges or phase entry
    if (accept || (period_end && state_q != S_IDLE && state_q != S_RSP))
      tdi_d = (state_d == S_SHIFT) ? sr_d[0] : 1'b0;

    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RSP);
    uir_d       = (state_d == S_UIR);
    cdr_d       = (state_d == S_CDR);
    sdr_d       = (state_d == S_SHIFT);
    udr_d       = (state_d == S_UDR);
    rti_d       = (state_d == S_RTI);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      rsp_data_q  <= '0;
      rsp_ir_q    <= '0;
      ir_in_q     <= '0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b0;
`ifdef DBG_HOST_IR_CACHE_EN
      ir_cache_q     <= '0;
      ir_cache_vld_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ir_q    <= rsp_ir_d;
      ir_in_q     <= ir_in_d;
      tck_q       <= tck_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      uir_q       <= uir_d;
      cdr_q       <= cdr_d;
      sdr_q       <= sdr_d;
      udr_q       <= udr_d;
      rti_q       <= rti_d;
`ifdef DBG_HOST_IR_CACHE_EN
      ir_cache_q     <= ir_cache_d;
      ir_cache_vld_q <= ir_cache_vld_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_ir_out = rsp_ir_q;
  assign vji_tck    = tck_q;
  assign vji_tdi    = tdi_q;
  assign vji_ir_in  = ir_in_q;
  assign vji_uir    = uir_q;
  assign vji_cdr    = cdr_q;
  assign vji_sdr    = sdr_q;
  assign vji_udr    = udr_q;
  assign vji_rti    = rti_q;

endmodule

`default_nettype wire

// File: tb/tb_platform_nios2_gen2_0_cpu_debug_host_shifter.sv
// Directed bench with a response scoreboard for the virtual JTAG debug host shifter.
`default_nettype none

module tb_platform_nios2_gen2_0_cpu_debug_host_shifter;

`ifdef DBG_HOST_IR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, cmd_valid, rsp_ready, tdo_force1;
  logic [1:0]  cmd_ir, ir_out_drv;
  logic [37:0] cmd_data;
  logic        cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_tdo;
  logic [37:0] rsp_data;
  logic [1:0]  rsp_ir_out, vji_ir_in;
  logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  assign vji_tdo = tdo_force1 ? 1'b1 : vji_tdi;

  platform_nios2_gen2_0_cpu_debug_host_shifter u_dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(ir_out_drv),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  // Second instance with the fastest TCK divider
  logic        c1_cmd_valid, c1_cmd_ready, c1_rsp_valid, c1_rsp_ready, c1_tck, c1_tdi;
  logic [37:0] c1_cmd_data, c1_rsp_data;
  logic [1:0]  c1_rsp_ir_out, c1_ir_in;
  logic        c1_uir, c1_cdr, c1_sdr, c1_udr, c1_rti;

  platform_nios2_gen2_0_cpu_debug_host_shifter #(.TCK_DIV(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(c1_cmd_valid), .cmd_ready(c1_cmd_ready), .cmd_ir(2'b01), .cmd_data(c1_cmd_data),
    .rsp_valid(c1_rsp_valid), .rsp_ready(c1_rsp_ready), .rsp_data(c1_rsp_data), .rsp_ir_out(c1_rsp_ir_out),
    .vji_tck(c1_tck), .vji_tdi(c1_tdi), .vji_tdo(c1_tdi),
    .vji_ir_in(c1_ir_in), .vji_ir_out(2'b00),
    .vji_uir(c1_uir), .vji_cdr(c1_cdr), .vji_sdr(c1_sdr), .vji_udr(c1_udr), .vji_rti(c1_rti)
  );

  typedef struct packed {
    logic [37:0] data;
    logic [1:0]  ir;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int sdr_edges = 0;
  int uir_cnt = 0;

  always @(posedge vji_tck) if (vji_sdr) sdr_edges++;
  always @(posedge clk) if (vji_uir) uir_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic [1:0] ir, input logic [37:0] data,
                           input logic [37:0] exp_data, input logic [1:0] exp_ir);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_before_accept", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_data  = data;
    sb.push_back({exp_data, exp_ir});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("cmd_ready_fall", cmd_ready, 0);
    chk("ir_in_latched", vji_ir_in, ir);
  endtask

  task automatic wait_rsp(input int exp_lat, input string tag);
    int lat = 0;
    while (!rsp_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    chk({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rsp_valid"}, rsp_valid, 1);
      chk({tag, "_rsp_data"}, rsp_data, e.data);
      chk({tag, "_rsp_ir_out"}, rsp_ir_out, e.ir);
    end
  endtask

  task automatic ack();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("cmd_ready_after_ack", cmd_ready, 1);
    chk("rsp_valid_after_ack", rsp_valid, 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_ir_out"}, rsp_ir_out, 0);
    chk({tag, "_ir_in"}, vji_ir_in, 0);
    chk({tag, "_strobes"}, {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 0);
    chk({tag, "_tck_tdi"}, {vji_tck, vji_tdi}, 0);
  endtask

  initial begin
    int snap, lat, n, seen;
    logic [37:0] d;
    reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; tdo_force1 = 1'b0;
    cmd_ir = '0; cmd_data = '0; ir_out_drv = '0;
    c1_cmd_valid = 1'b0; c1_rsp_ready = 1'b0; c1_cmd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    reset_n = 1'b1;

    // Loopback: data returns unchanged, 38 shift edges
    snap = sdr_edges;
    start_cmd(2'b01, 38'h2A_5555_AAAA, 38'h2A_5555_AAAA, 2'b00);
    wait_rsp(168, "loop");
    chk("loop_sdr_edges", sdr_edges - snap, 38);
    check_rsp("loop");
    ack();

    // TDO tied high, IR status captured
    tdo_force1 = 1'b1; ir_out_drv = 2'b10;
    start_cmd(2'b10, 38'h0, 38'h3F_FFFF_FFFF, 2'b10);
    wait_rsp(168, "ones");
    check_rsp("ones");
    ack();

    // Back-pressure: response held, new command ignored
    tdo_force1 = 1'b0; ir_out_drv = 2'b01;
    d = 38'h12_3456_789A;
    start_cmd(2'b01, d, d, 2'b01);
    wait_rsp(168, "stall");
    check_rsp("stall");
    snap = uir_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cmd_valid = (i == 5);
      cmd_ir    = 2'b11;
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_data", rsp_data, d);
      chk("stall_cmd_ready", cmd_ready, 0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    ack();
    repeat (10) @(negedge clk);
    chk("stall_no_queued_cmd", {cmd_ready, 32'(uir_cnt - snap)}, {1'b1, 32'd0});

    // Reset in the middle of SHIFT
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = 2'b11; cmd_data = 38'h15_0F0F_3C3C;
    snap = sdr_edges;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while ((sdr_edges - snap) < 17 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_bit17", sdr_edges - snap, 17);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_reset_state("abort");
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", seen, 0);

    // Two commands with the same IR; the second may skip UIR
    ir_out_drv = 2'b01;
    d = 38'h0A_BCDE_F012;
    start_cmd(2'b11, d, d, 2'b01);
    wait_rsp(168, "ir_first");
    check_rsp("ir_first");
    ack();
    ir_out_drv = 2'b10;
    snap = uir_cnt;
    d = 38'h35_A5A5_5A5A;
    start_cmd(2'b11, d, d, CACHE ? 2'b01 : 2'b10);
    wait_rsp(CACHE ? 164 : 168, "ir_second");
    chk("ir_second_uir_cycles", uir_cnt - snap, CACHE ? 0 : 4);
    check_rsp("ir_second");
    ack();

    // TCK_DIV=1 instance: 2-cycle TCK, 84-cycle latency
    @(negedge clk);
    c1_cmd_valid = 1'b1;
    c1_cmd_data  = 38'h2C_3333_CCCC;
    @(posedge clk);
    #1;
    c1_cmd_valid = 1'b0;
    lat = 0;
    while (!c1_rsp_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat <= 4) chk("div1_tck_phase", c1_tck, lat % 2);
    end
    chk("div1_latency", lat, 84);
    chk("div1_rsp_data", c1_rsp_data, 38'h2C_3333_CCCC);
    @(negedge clk);
    c1_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    c1_rsp_ready = 1'b0;
    chk("div1_cmd_ready", c1_cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
